// File: rtl/commit_storebuffer.sv
// commit_storebuffer
//   Data side of the store-buffer credit scheme. Stores are written at allocation,
//   marked committed in program order at retirement, and drained in order to the
//   data-cache write port through a valid/ready handshake. A pipeline flush
//   (snoop_hit or bco_valid) discards every uncommitted entry. Committed entries
//   survive a flush and keep draining.
//
//   Ports
//     clk, resetn                      clock, synchronous active-low reset
//     snoop_hit, bco_valid             flush requests
//     en_alloc, en_alloc_store         allocation strobe (write = both)
//     alloc_addr/data/strb             store payload
//     alloc_ready                      buffer not full
//     en_commit, en_commit_store       retirement strobe (commit = both)
//     drain_valid/addr/data/strb       oldest committed entry
//     drain_ready                      cache accepts the head entry
//     sb_empty, sb_count               occupancy status
module commit_storebuffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     snoop_hit,
  input  logic                     bco_valid,
  input  logic                     en_alloc,
  input  logic                     en_alloc_store,
  input  logic [AW-1:0]            alloc_addr,
  input  logic [DW-1:0]            alloc_data,
  input  logic [DW/8-1:0]          alloc_strb,
  output logic                     alloc_ready,
  input  logic                     en_commit,
  input  logic                     en_commit_store,
  output logic                     drain_valid,
  output logic [AW-1:0]            drain_addr,
  output logic [DW-1:0]            drain_data,
  output logic [DW/8-1:0]          drain_strb,
  input  logic                     drain_ready,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // [head, cmt) is committed, [cmt, tail) is uncommitted.
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] cmt_q,  cmt_d;
  logic [PW-1:0] tail_q, tail_d;

  // Entry storage is never reset; pointers alone define validity.
  logic [AW-1:0]   addr_mem [DEPTH];
  logic [DW-1:0]   data_mem [DEPTH];
  logic [DW/8-1:0] strb_mem [DEPTH];

  logic [PW-1:0] occ;
  logic          full;
  logic          flush;
  logic          do_write;
  logic          do_commit;
  logic          do_drain;

  assign occ       = tail_q - head_q;
  assign full      = (occ == DEPTH_P);
  assign flush     = snoop_hit | bco_valid;
  // A write in a flush cycle would land in the uncommitted region being discarded.
  assign do_write  = en_alloc & en_alloc_store & ~full & ~flush;
  assign do_commit = en_commit & en_commit_store & (cmt_q != tail_q);
  assign do_drain  = drain_valid & drain_ready;

  always_comb begin
    head_d = head_q + {{(PW-1){1'b0}}, do_drain};
    cmt_d  = cmt_q  + {{(PW-1){1'b0}}, do_commit};
    // Flush trims the tail back to the commit boundary, including a same-cycle commit.
    if (flush) begin
      tail_d = cmt_d;
    end else begin
      tail_d = tail_q + {{(PW-1){1'b0}}, do_write};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      addr_mem[tail_q[IW-1:0]] <= alloc_addr;
      data_mem[tail_q[IW-1:0]] <= alloc_data;
      strb_mem[tail_q[IW-1:0]] <= alloc_strb;
    end
  end

  assign alloc_ready = ~full;
  assign drain_valid = (head_q != cmt_q);
  assign drain_addr  = addr_mem[head_q[IW-1:0]];
  assign drain_data  = data_mem[head_q[IW-1:0]];
  assign drain_strb  = strb_mem[head_q[IW-1:0]];
  assign sb_empty    = (head_q == tail_q);
  assign sb_count    = occ;

endmodule

// File: tb/tb_commit_storebuffer.sv
// Directed bench for commit_storebuffer. A reference model keeps two queues of
// expected entries (uncommitted and committed); every cycle the DUT status and
// head payload are compared against it and the model is advanced at the edge.
module tb_commit_storebuffer;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int PL    = AW + DW + SW;

  logic                   clk;
  logic                   resetn;
  logic                   snoop_hit;
  logic                   bco_valid;
  logic                   en_alloc;
  logic                   en_alloc_store;
  logic [AW-1:0]          alloc_addr;
  logic [DW-1:0]          alloc_data;
  logic [SW-1:0]          alloc_strb;
  logic                   alloc_ready;
  logic                   en_commit;
  logic                   en_commit_store;
  logic                   drain_valid;
  logic [AW-1:0]          drain_addr;
  logic [DW-1:0]          drain_data;
  logic [SW-1:0]          drain_strb;
  logic                   drain_ready;
  logic                   sb_empty;
  logic [$clog2(DEPTH):0] sb_count;

  int vectors;
  int miscompares;

  logic [PL-1:0] pend[$];
  logic [PL-1:0] cq[$];

  commit_storebuffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn), .snoop_hit(snoop_hit), .bco_valid(bco_valid),
    .en_alloc(en_alloc), .en_alloc_store(en_alloc_store),
    .alloc_addr(alloc_addr), .alloc_data(alloc_data), .alloc_strb(alloc_strb),
    .alloc_ready(alloc_ready), .en_commit(en_commit), .en_commit_store(en_commit_store),
    .drain_valid(drain_valid), .drain_addr(drain_addr), .drain_data(drain_data),
    .drain_strb(drain_strb), .drain_ready(drain_ready),
    .sb_empty(sb_empty), .sb_count(sb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [PL-1:0] obs, input logic [PL-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic cyc();
    int cnt;
    cnt = pend.size() + cq.size();
    @(negedge clk);
    chk("alloc_ready", PL'(alloc_ready), PL'(cnt < DEPTH));
    chk("drain_valid", PL'(drain_valid), PL'(cq.size() > 0));
    chk("sb_empty",    PL'(sb_empty),    PL'(cnt == 0));
    chk("sb_count",    PL'(sb_count),    PL'(cnt));
    if (cq.size() > 0) chk("payload", {drain_addr, drain_data, drain_strb}, cq[0]);
    @(posedge clk);
    if (!resetn) begin
      pend.delete();
      cq.delete();
    end else begin
      if (cq.size() > 0 && drain_ready) void'(cq.pop_front());
      if (en_commit && en_commit_store && pend.size() > 0) cq.push_back(pend.pop_front());
      if (snoop_hit || bco_valid) pend.delete();
      else if (en_alloc && en_alloc_store && cnt < DEPTH)
        pend.push_back({alloc_addr, alloc_data, alloc_strb});
    end
    #1;
  endtask

  task automatic set_alloc(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s);
    en_alloc       = en;
    en_alloc_store = en;
    alloc_addr     = a;
    alloc_data     = d;
    alloc_strb     = s;
  endtask

  task automatic set_commit(input logic en);
    en_commit       = en;
    en_commit_store = en;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    snoop_hit   = 1'b0;
    bco_valid   = 1'b0;
    drain_ready = 1'b0;
    set_alloc(1'b0, '0, '0, '0);
    set_commit(1'b0);
    @(posedge clk);
    #1;

    // Reset state
    cyc();
    resetn = 1'b1;
    cyc();

    // Single store: alloc, commit, drain
    set_alloc(1'b1, 32'h100, 32'hAA, 4'hF);
    cyc();
    set_alloc(1'b0, '0, '0, '0);
    set_commit(1'b1);
    cyc();
    set_commit(1'b0);
    drain_ready = 1'b1;
    cyc();
    cyc();

    // Fill without commit, 9th write dropped, then flush
    drain_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_alloc(1'b1, 32'h2000 + 32'(i * 4), 32'hD000 + 32'(i), 4'(i + 1));
      cyc();
    end
    set_alloc(1'b0, '0, '0, '0);
    cyc();
    snoop_hit = 1'b1;
    cyc();
    snoop_hit = 1'b0;
    cyc();

    // Alloc 3, commit 2, flush together with the 3rd commit
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b1, 32'h3000 + 32'(i * 8), 32'hC0DE0000 + 32'(i), 4'b0011 << i);
      cyc();
    end
    set_alloc(1'b0, '0, '0, '0);
    set_commit(1'b1);
    cyc();
    cyc();
    bco_valid = 1'b1;
    cyc();
    bco_valid = 1'b0;
    set_commit(1'b0);
    drain_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();

    // Back-pressure with two committed, payload must hold
    drain_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_alloc(1'b1, 32'h4000 + 32'(i), 32'hBEEF0000 + 32'(i), 4'hA);
      cyc();
    end
    set_alloc(1'b0, '0, '0, '0);
    set_commit(1'b1);
    cyc();
    cyc();
    set_commit(1'b0);
    for (int i = 0; i < 5; i++) cyc();

    // Mixed alloc/commit/drain traffic across pointer wrap
    for (int i = 0; i < 40; i++) begin
      set_alloc(($urandom_range(0, 3) != 0), $urandom(), $urandom(), 4'($urandom()));
      set_commit($urandom_range(0, 3) != 0);
      drain_ready = $urandom_range(0, 1) != 0;
      bco_valid   = ($urandom_range(0, 15) == 0);
      cyc();
    end
    set_alloc(1'b0, '0, '0, '0);
    bco_valid   = 1'b0;
    set_commit(1'b1);
    drain_ready = 1'b1;
    for (int i = 0; i < 20; i++) cyc();

    // Commit with nothing uncommitted is ignored
    cyc();
    set_commit(1'b0);
    set_alloc(1'b1, 32'h5000, 32'h55, 4'h5);
    cyc();
    set_alloc(1'b1, 32'h5004, 32'h66, 4'h6);
    cyc();
    set_alloc(1'b0, '0, '0, '0);
    drain_ready = 1'b0;
    set_commit(1'b1);
    cyc();
    cyc();
    set_commit(1'b0);
    // Reset in the middle of draining
    drain_ready = 1'b1;
    cyc();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
